// File: rtl/sha1_core_arbiter.sv
// sha1_core_arbiter: round-robin sharing of one SHA-1 compression core among
// NUM_REQ requesters. Accepts one {context, block} job at a time, holds the core
// inputs stable, pulses core_start, waits for core_done and returns the result.
// Optional watchdog: define SHA1_ARB_TIMEOUT_EN to time out hung jobs and add
// the FLUSH state; when undefined, WAIT waits indefinitely and rsp_error is 0.
module sha1_core_arbiter #(
  parameter  int unsigned NUM_REQ        = 4,
  parameter  int unsigned ID_W           = $clog2(NUM_REQ),
  parameter  int unsigned TIMEOUT_CYCLES = 1023,
  localparam int unsigned CTX_W          = 160,
  localparam int unsigned BLK_W          = 512
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*CTX_W-1:0] req_context,
  input  logic [NUM_REQ*BLK_W-1:0] req_block,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     core_start,
  output logic [CTX_W-1:0]         core_context_in,
  output logic [BLK_W-1:0]         core_block,
  input  logic                     core_done,
  input  logic [CTX_W-1:0]         core_context_out,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [CTX_W-1:0]         rsp_context,
  output logic                     rsp_error,
  output logic [ID_W-1:0]          grant_id,
  output logic                     busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
`ifdef SHA1_ARB_TIMEOUT_EN
    ,
    S_FLUSH = 2'd3
`endif
  } state_t;

  state_t               r_state;
  logic [ID_W-1:0]      r_last_grant;
  logic [ID_W-1:0]      r_grant_id;
  logic [NUM_REQ-1:0]   r_req_ready;
  logic [NUM_REQ-1:0]   r_rsp_valid;
  logic                 r_core_start;
  logic [CTX_W-1:0]     r_core_ctx;
  logic [BLK_W-1:0]     r_core_blk;
  logic [CTX_W-1:0]     r_rsp_context;
  logic                 r_busy;

  logic                 w_any;
  logic [ID_W-1:0]      w_winner;
  logic [CTX_W-1:0]     w_sel_ctx;
  logic [BLK_W-1:0]     w_sel_blk;

`ifdef SHA1_ARB_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0]      r_wdog;
  logic                 r_rsp_error;
`else
  logic [31:0]          w_unused_timeout;
  assign w_unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

  // Round-robin pick: first valid requester searching upward from last_grant+1
  always_comb begin
    int unsigned v_idx;
    w_any    = 1'b0;
    w_winner = '0;
    v_idx    = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      v_idx = 32'(r_last_grant) + k;
      if (v_idx >= NUM_REQ) v_idx = v_idx - NUM_REQ;
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!w_any && (v_idx == j) && req_valid[j]) begin
          w_any    = 1'b1;
          w_winner = ID_W'(j);
        end
      end
    end
  end

  // Select the winner's context and block for latching into the core inputs
  always_comb begin
    w_sel_ctx = '0;
    w_sel_blk = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (ID_W'(k) == w_winner) begin
        w_sel_ctx = req_context[k*CTX_W +: CTX_W];
        w_sel_blk = req_block[k*BLK_W +: BLK_W];
      end
    end
  end

  // Sequencer: accept, start the core, collect the result (or time out)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_last_grant  <= ID_W'(NUM_REQ - 1);
      r_grant_id    <= '0;
      r_req_ready   <= '0;
      r_rsp_valid   <= '0;
      r_core_start  <= 1'b0;
      r_core_ctx    <= '0;
      r_core_blk    <= '0;
      r_rsp_context <= '0;
      r_busy        <= 1'b0;
`ifdef SHA1_ARB_TIMEOUT_EN
      r_wdog        <= '0;
      r_rsp_error   <= 1'b0;
`endif
    end else begin
      r_req_ready  <= '0;
      r_rsp_valid  <= '0;
      r_core_start <= 1'b0;
`ifdef SHA1_ARB_TIMEOUT_EN
      r_rsp_error  <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_req_ready <= NUM_REQ'(1) << w_winner;
            r_core_ctx  <= w_sel_ctx;
            r_core_blk  <= w_sel_blk;
            r_grant_id  <= w_winner;
            r_busy      <= 1'b1;
            r_state     <= S_START;
          end
        end
        S_START: begin
          r_core_start <= 1'b1;
          r_state      <= S_WAIT;
`ifdef SHA1_ARB_TIMEOUT_EN
          r_wdog       <= '0;
`endif
        end
        S_WAIT: begin
          // done on the limit cycle still counts as a normal completion
          if (core_done) begin
            r_rsp_context <= core_context_out;
            r_rsp_valid   <= NUM_REQ'(1) << r_grant_id;
            r_last_grant  <= r_grant_id;
            r_busy        <= 1'b0;
            r_state       <= S_IDLE;
          end
`ifdef SHA1_ARB_TIMEOUT_EN
          else if (r_wdog == WD_W'(TIMEOUT_CYCLES)) begin
            r_rsp_context <= '0;
            r_rsp_valid   <= NUM_REQ'(1) << r_grant_id;
            r_rsp_error   <= 1'b1;
            r_last_grant  <= r_grant_id;
            r_wdog        <= '0;
            r_state       <= S_FLUSH;
          end else begin
            r_wdog <= r_wdog + WD_W'(1);
          end
`endif
        end
`ifdef SHA1_ARB_TIMEOUT_EN
        S_FLUSH: begin
          // absorb the late done of the abandoned job, or give up after another limit
          if (core_done || (r_wdog == WD_W'(TIMEOUT_CYCLES))) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_wdog <= r_wdog + WD_W'(1);
          end
        end
`endif
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready       = r_req_ready;
  assign rsp_valid       = r_rsp_valid;
  assign core_start      = r_core_start;
  assign core_context_in = r_core_ctx;
  assign core_block      = r_core_blk;
  assign rsp_context     = r_rsp_context;
  assign grant_id        = r_grant_id;
  assign busy            = r_busy;
`ifdef SHA1_ARB_TIMEOUT_EN
  assign rsp_error       = r_rsp_error;
`else
  assign rsp_error       = 1'b0;
`endif

endmodule

// File: doc/sha1_core_arbiter.md
# sha1_core_arbiter

Round-robin arbiter and sequencer that shares one `sha1_block` compression core between `NUM_REQ` independent requesters, for example several nonce searchers or message hashers. It accepts a `{context, block}` job from one requester at a time and holds the core inputs stable for the whole compression. It pulses the core start, waits for core done, and returns the resulting context to the owning requester. It sits between the requester array and the single core instance.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `ID_W`, `$clog2(NUM_REQ)`: width of the grant index.
- `TIMEOUT_CYCLES`, 1023: watchdog limit. Used only with `SHA1_ARB_TIMEOUT_EN`.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  NUM_REQ  bit i: requester i has a job.
- `req_context`  in  NUM_REQ*160  context for requester i, at bits [160*i +: 160].
- `req_block`  in  NUM_REQ*512  block for requester i, at bits [512*i +: 512].
- `req_ready`  out  NUM_REQ  one-hot acceptance pulse.
- `core_start`  out  1  one-cycle start pulse to the core.
- `core_context_in`  out  160  registered context to the core.
- `core_block`  out  512  registered block to the core.
- `core_done`  in  1  one-cycle done pulse from the core.
- `core_context_out`  in  160  core result, valid with `core_done`.
- `rsp_valid`  out  NUM_REQ  one-hot, one-cycle result pulse.
- `rsp_context`  out  160  result for the pulsed requester.
- `rsp_error`  out  1  qualifies `rsp_valid`: job timed out, and `rsp_context` is 0.
- `grant_id`  out  ID_W  index of the current or last owner.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, START, WAIT, FLUSH. FLUSH exists only with the macro.
- **IDLE:**
  - If any `req_valid` is set, pick the first set bit searching upward from `last_grant+1`, modulo NUM_REQ.
  - In the same cycle: assert `req_ready[winner]`, latch that requester's context and block into `core_context_in`/`core_block`, set `grant_id` to the winner, and go to START.
- **START:** `core_start`=1 for exactly this cycle, then go to WAIT.
- **WAIT:** on `core_done`:
  - Register `rsp_context` <= `core_context_out`.
  - Set `rsp_valid[grant_id]`=1 for the next cycle.
  - Set `last_grant` <= `grant_id` and go to IDLE.
- A requester must hold `req_valid` and its data until it sees `req_ready`. It may drop `req_valid` at any time before that with no effect.
- `core_context_in`/`core_block` change only on acceptance. They are stable from START until the response.
- `core_done` is ignored in IDLE and START. A stray pulse produces no response.
- A requester may reissue a job in the same cycle its `rsp_valid` is high. That job is eligible for arbitration in that IDLE cycle, subject to round-robin order.
- Reset values:
  - state=IDLE, `last_grant`=NUM_REQ-1, so requester 0 wins first.
  - `grant_id`=0, `rsp_context`=0, `core_context_in`=0, `core_block`=0.
  - All of `req_ready`, `rsp_valid`, `core_start`, `rsp_error`, `busy` are 0.
- Reset mid-job drops the job silently: no response is issued and the requester must resubmit. A `core_done` that arrives after reset is ignored.

## Timing
- Acceptance to `core_start`: 1 cycle.
- `core_done` to `rsp_valid`: 1 cycle.
- Arbitration overhead per job: 2 cycles (IDLE plus START) added to the core latency.
- Back-to-back jobs: the next `core_start` comes 2 cycles after `rsp_valid`.
- Fairness: while requester i is waiting, each other requester gets at most one grant.

## Configuration
- **`SHA1_ARB_TIMEOUT_EN` defined:**
  - A watchdog counter clears on entering WAIT and increments each WAIT cycle.
  - When it reaches `TIMEOUT_CYCLES` with no `core_done`:
    - Set `rsp_valid[grant_id]`=1 and `rsp_error`=1 next cycle, with `rsp_context`=0.
    - Go to FLUSH and reset the counter.
  - FLUSH waits for `core_done` or a further `TIMEOUT_CYCLES`, then goes to IDLE. A `core_done` in FLUSH is absorbed without a response.
  - `core_done` on the same cycle the counter hits the limit counts as normal completion.
- **Undefined:** no counter and no FLUSH state. `rsp_error` is tied to 0 and WAIT waits indefinitely.

## Test plan
- **Single job:** requester 2 sends the standard IV 67452301_efcdab89_98badcfe_10325476_c3d2e1f0 with the padded "abc" block 61626380_0…0_00000018.
  - `req_ready`=4'b0100, then `core_start` 1 cycle later.
  - `rsp_valid`=4'b0100 with `rsp_context`=a9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d.
- **All four requesters valid at once after reset:** grants go in order 0,1,2,3, then wrap to 0. Each gets exactly one response with the correct context.
- **Requesters 1 and 3 stay valid continuously:** grants alternate 1,3,1,3. The gap from `rsp_valid` to the next `core_start` is always 2 cycles.
- **Stray `core_done` in IDLE, and `rst_n` pulled low during WAIT:**
  - No `rsp_valid` for either.
  - All outputs go to their reset values immediately on `rst_n` low.
  - The first grant after reset goes to requester 0.
- **Macro defined, `TIMEOUT_CYCLES`=8, core never signals done:**
  - `rsp_valid`=one-hot owner with `rsp_error`=1 and `rsp_context`=0, 9 cycles after `core_start`.
  - A late `core_done` during FLUSH produces no response.
- **Macro undefined:** the same stimulus as the timeout scenario produces no response, and `busy` stays 1.
